// File: rtl/alu_mc_pkg.sv
// Shared constants and types for the ALU / multiplier execute unit.
package alu_mc_pkg;

   // alu_op encodings
   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_SUB = 2'b01;
   localparam logic [1:0] ALU_OP_FN  = 2'b10;
   localparam logic [1:0] ALU_OP_ILL = 2'b11;

   // MIPS R-type funct codes understood by the unit
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;

   // Internal operation after decode
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
      OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_ILL
   } op_e;

   // Control FSM states
   typedef enum logic [1:0] {
      S_IDLE, S_MUL, S_FIX
   } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute-stage controller and the ALU unit.
interface alu_mc_if #(parameter int WIDTH = 32);
   logic             valid_i;
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready_o;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             err;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid_i, alu_op, funct, a, b,
      input  ready_o, done, result, zero, err, hi, lo
   );

   modport slave (
      input  valid_i, alu_op, funct, a, b,
      output ready_o, done, result, zero, err, hi, lo
   );
endinterface

// File: rtl/alu_mc_decode.sv
// Combinational control decode: alu_op + funct -> internal operation.
// Multiplier-related functts fold into OP_ILL when the multiplier is not built.
module alu_mc_decode
   import alu_mc_pkg::*;
#(
   parameter bit MUL_EN = 1'b1
) (
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output op_e        op,
   output logic       illegal
);

   // Map the opcode/funct pair onto one internal operation
   always_comb begin
      op = OP_ILL;
      case (alu_op)
         ALU_OP_ADD: op = OP_ADD;
         ALU_OP_SUB: op = OP_SUB;
         ALU_OP_FN: begin
            case (funct)
               FN_ADD:   op = OP_ADD;
               FN_SUB:   op = OP_SUB;
               FN_AND:   op = OP_AND;
               FN_OR:    op = OP_OR;
               FN_XOR:   op = OP_XOR;
               FN_NOR:   op = OP_NOR;
               FN_SLT:   op = OP_SLT;
               FN_SLTU:  op = OP_SLTU;
               FN_MFHI:  if (MUL_EN) op = OP_MFHI;  else op = OP_ILL;
               FN_MFLO:  if (MUL_EN) op = OP_MFLO;  else op = OP_ILL;
               FN_MULT:  if (MUL_EN) op = OP_MULT;  else op = OP_ILL;
               FN_MULTU: if (MUL_EN) op = OP_MULTU; else op = OP_ILL;
               default:  op = OP_ILL;
            endcase
         end
         default: op = OP_ILL;
      endcase
   end

   assign illegal = (op == OP_ILL);

endmodule

// File: rtl/alu_mc_unit.sv
// Execute-stage ALU with single-cycle ops, an iterative shift-add multiplier
// feeding HI/LO, and a done pulse per completed operation.
module alu_mc_unit
   import alu_mc_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   op_e              op_s;
   logic             illegal_s;
   state_e           state_r;
   state_e           state_nx_s;
   logic             accept_s;
   logic             mul_op_s;
   logic             last_step_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH-1:0] mul_hi_s;
   logic [WIDTH-1:0] mul_lo_s;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             done_r;
   logic             zero_r;
   logic             err_r;

   alu_mc_decode #(.MUL_EN(MUL_EN)) u_decode (
      .alu_op  (bus.alu_op),
      .funct   (bus.funct),
      .op      (op_s),
      .illegal (illegal_s)
   );

   assign accept_s = bus.valid_i & (state_r == S_IDLE);
   assign mul_op_s = (op_s == OP_MULT) || (op_s == OP_MULTU);

   // Single-cycle datapath; illegal and multiply ops produce zero here
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      case (op_s)
         OP_ADD:  alu_res_s = bus.a + bus.b;
         OP_SUB:  alu_res_s = bus.a - bus.b;
         OP_AND:  alu_res_s = bus.a & bus.b;
         OP_OR:   alu_res_s = bus.a | bus.b;
         OP_XOR:  alu_res_s = bus.a ^ bus.b;
         OP_NOR:  alu_res_s = ~(bus.a | bus.b);
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_MFHI: alu_res_s = hi_r;
         OP_MFLO: alu_res_s = lo_r;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Next-state logic: only an accepted multiply leaves IDLE
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s && mul_op_s) state_nx_s = S_MUL;
            else                      state_nx_s = S_IDLE;
         end
         S_MUL: begin
            if (last_step_s) state_nx_s = S_FIX;
            else             state_nx_s = S_MUL;
         end
         S_FIX:   state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= state_nx_s;
   end

   generate
      if (MUL_EN) begin : g_mul
         logic [2*WIDTH-1:0] prod_r;
         logic [2*WIDTH-1:0] prod_fix_s;
         logic [WIDTH-1:0]   mcand_r;
         logic               neg_r;
         logic [CNT_W-1:0]   cnt_r;
         logic [WIDTH:0]     sum_s;
         logic               sgn_s;
         logic [WIDTH-1:0]   mag_a_s;
         logic [WIDTH-1:0]   mag_b_s;

         // Signed multiply works on magnitudes; the most negative value's
         // magnitude still fits as an unsigned WIDTH-bit number.
         assign sgn_s   = (op_s == OP_MULT);
         assign mag_a_s = (sgn_s && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
         assign mag_b_s = (sgn_s && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;

         // Upper half plus multiplicand when the current multiplier bit is set
         assign sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                      + {1'b0, (prod_r[0] ? mcand_r : {WIDTH{1'b0}})};

         assign prod_fix_s  = neg_r ? ({(2*WIDTH){1'b0}} - prod_r) : prod_r;
         assign mul_hi_s    = prod_fix_s[2*WIDTH-1:WIDTH];
         assign mul_lo_s    = prod_fix_s[WIDTH-1:0];
         assign last_step_s = (state_r == S_MUL) && (cnt_r == CNT_W'(WIDTH-1));

         // Operand capture on accept, then one shift-add step per MUL cycle
         always_ff @(posedge clk) begin
            if (rst) begin
               prod_r  <= {(2*WIDTH){1'b0}};
               mcand_r <= {WIDTH{1'b0}};
               neg_r   <= 1'b0;
               cnt_r   <= {CNT_W{1'b0}};
            end else if (accept_s && mul_op_s) begin
               prod_r  <= {{WIDTH{1'b0}}, mag_b_s};
               mcand_r <= mag_a_s;
               neg_r   <= sgn_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               cnt_r   <= {CNT_W{1'b0}};
            end else if (state_r == S_MUL) begin
               prod_r  <= {sum_s, prod_r[WIDTH-1:1]};
               cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end else begin : g_nomul
         assign mul_hi_s    = {WIDTH{1'b0}};
         assign mul_lo_s    = {WIDTH{1'b0}};
         assign last_step_s = 1'b0;
      end
   endgenerate

   // Output registers: single-cycle ops complete on accept, multiply in FIX
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r <= {WIDTH{1'b0}};
         zero_r   <= 1'b1;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         if (state_r == S_FIX) begin
            result_r <= mul_lo_s;
            zero_r   <= (mul_lo_s == {WIDTH{1'b0}});
            hi_r     <= mul_hi_s;
            lo_r     <= mul_lo_s;
            done_r   <= 1'b1;
         end else if (accept_s && !mul_op_s) begin
            result_r <= alu_res_s;
            zero_r   <= (alu_res_s == {WIDTH{1'b0}});
            err_r    <= illegal_s;
            done_r   <= 1'b1;
         end
      end
   end

   assign bus.ready_o = (state_r == S_IDLE);
   assign bus.done    = done_r;
   assign bus.result  = result_r;
   assign bus.zero    = zero_r;
   assign bus.err     = err_r;
   assign bus.hi      = hi_r;
   assign bus.lo      = lo_r;

endmodule
